// File: rtl/regfile_mp_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb_if
// Bundles the datapath-facing signals of regfile_mp_sb.
//
// Signal summary:
//   in_SR        decode -> rf   read addresses, port k at [k*ADDR_W +: ADDR_W]
//   out_PR       rf -> decode   read data, port k at [k*DATA_W +: DATA_W]
//   out_pend     rf -> decode   pending flag of the register read by port k
//   in_SC        wb -> rf       write address
//   in_PC        wb -> rf       write data
//   in_RFL       wb -> rf       write enable
//   in_rsv       decode -> rf   reserve (mark pending) in_rsv_addr
//   in_rsv_addr  decode -> rf   register to reserve
//   in_clr_req   ctrl -> rf     start a sweep clear
//   out_busy     rf -> ctrl     sweep in progress
//   out_done     rf -> ctrl     one-cycle pulse when the sweep completes
//   out_dbg_state rf -> any     current sweep FSM state (0 idle, 1 sweep, 2 done)
//
// Modports: master = the datapath driving the file, slave = the register file.
// -----------------------------------------------------------------------------
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] in_SR;
    logic [NUM_RD*DATA_W-1:0] out_PR;
    logic [NUM_RD-1:0]        out_pend;
    logic [ADDR_W-1:0]        in_SC;
    logic [DATA_W-1:0]        in_PC;
    logic                     in_RFL;
    logic                     in_rsv;
    logic [ADDR_W-1:0]        in_rsv_addr;
    logic                     in_clr_req;
    logic                     out_busy;
    logic                     out_done;
    logic [1:0]               out_dbg_state;

    modport master (
        output in_SR, in_SC, in_PC, in_RFL, in_rsv, in_rsv_addr, in_clr_req,
        input  out_PR, out_pend, out_busy, out_done, out_dbg_state
    );

    modport slave (
        input  in_SR, in_SC, in_PC, in_RFL, in_rsv, in_rsv_addr, in_clr_req,
        output out_PR, out_pend, out_busy, out_done, out_dbg_state
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
// Parametrised multi-read-port register file with a per-register pending-write
// scoreboard and a multi-cycle sweep that zeroes the array without a reset.
//
// Ports:
//   in_clk  clock
//   clr_n   synchronous active-low reset (overrides every other input)
//   bus     regfile_mp_sb_if.slave; see the interface file for signal meanings
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read that matches an accepted write this cycle returns the
//                write data combinationally (write-through) and reports not
//                pending unless a reserve hits the same register this cycle.
//   undefined -> reads always return stored contents.
//
// Handshake: there is no backpressure. A write is accepted only in IDLE, for an
// in-range address that is not the hardwired zero register; anything else is
// silently dropped. Reserves follow the same acceptance rule. Sweep requests are
// honoured only in IDLE. out_busy is high for exactly NUM_REGS cycles, followed
// by a single out_done cycle.
//
// The interface instance must be built with the same DATA_W/ADDR_W/NUM_RD.
// -----------------------------------------------------------------------------
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            in_clk,
    input  logic            clr_n,
    regfile_mp_sb_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   LP_NUM_REGS = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LP_LAST     = ADDR_W'(NUM_REGS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;

    logic                     w_idle;
    logic                     w_wr_ok;
    logic                     w_rsv_ok;
    logic [ADDR_W-1:0]        w_rd_addr;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]        w_rd_pend;

    // An address names a real, writable register: in range and not the
    // hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < LP_NUM_REGS) && !((ZERO_REG == 1) && (a == '0));
    endfunction

    assign w_idle   = (r_state == ST_IDLE);
    assign w_wr_ok  = bus.in_RFL && w_idle && addr_ok(bus.in_SC);
    assign w_rsv_ok = bus.in_rsv && w_idle && addr_ok(bus.in_rsv_addr);

    // ---------------- sweep FSM ----------------
    always_ff @(posedge in_clk) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (bus.in_clr_req) w_next_state = ST_SWEEP;
            ST_SWEEP: if (r_idx == LP_LAST) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Index sits at 0 outside a sweep, so every sweep starts from register 0.
    // It holds at the last register instead of wrapping.
    always_ff @(posedge in_clk) begin
        if (!clr_n) begin
            r_idx <= '0;
        end else if (r_state != ST_SWEEP) begin
            r_idx <= '0;
        end else if (r_idx != LP_LAST) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // ---------------- storage and scoreboard ----------------
    always_ff @(posedge in_clk) begin
        if (!clr_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((r_state == ST_SWEEP) && (r_idx == ADDR_W'(i))) begin
                    r_regs[i] <= '0;
                    r_pend[i] <= 1'b0;
                end else begin
                    if (w_wr_ok && (bus.in_SC == ADDR_W'(i))) begin
                        r_regs[i] <= bus.in_PC;
                        r_pend[i] <= 1'b0;
                    end
                    // Placed after the write clear: a reserve in the same
                    // cycle names a new producer, so it wins.
                    if (w_rsv_ok && (bus.in_rsv_addr == ADDR_W'(i))) begin
                        r_pend[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- read ports ----------------
    always_comb begin
        w_rd_data = '0;
        w_rd_pend = '0;
        w_rd_addr = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_addr = bus.in_SR[k*ADDR_W +: ADDR_W];
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_ok(w_rd_addr) && (w_rd_addr == ADDR_W'(i))) begin
                    w_rd_data[k*DATA_W +: DATA_W] = r_regs[i];
                    w_rd_pend[k]                  = r_pend[i];
                end
            end
`ifdef REGFILE_BYPASS_EN
            // w_wr_ok already excludes the hardwired zero register.
            if (w_wr_ok && (w_rd_addr == bus.in_SC)) begin
                w_rd_data[k*DATA_W +: DATA_W] = bus.in_PC;
                w_rd_pend[k] = w_rsv_ok && (bus.in_rsv_addr == bus.in_SC);
            end
`endif
        end
    end

    assign bus.out_PR        = w_rd_data;
    assign bus.out_pend      = w_rd_pend;
    assign bus.out_busy      = (r_state == ST_SWEEP);
    assign bus.out_done      = (r_state == ST_DONE);
    assign bus.out_dbg_state = r_state;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Self-checking bench for regfile_mp_sb (32 x 32, two read ports, r0 = 0).
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 32;
    localparam int NRD = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD)) bus ();

    regfile_mp_sb #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(NRD), .ZERO_REG(1)
    ) dut (
        .in_clk(clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [DW-1:0] got);
        logic [DW-1:0] e;
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check(tag, got, e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        bus.in_SR[k*AW +: AW] = a;
    endtask

    task automatic expect_rd(input string tag, input int k, input logic [AW-1:0] a,
                             input logic [DW-1:0] exp);
        set_rd(k, a);
        #1;
        push_exp(exp);
        pop_check(tag, bus.out_PR[k*DW +: DW]);
    endtask

    task automatic expect_pend(input string tag, input int k, input logic [AW-1:0] a,
                               input logic exp);
        set_rd(k, a);
        #1;
        push_exp(exp ? 32'd1 : 32'd0);
        pop_check(tag, {31'd0, bus.out_pend[k]});
    endtask

    task automatic expect_sig(input string tag, input logic [DW-1:0] got,
                              input logic [DW-1:0] exp);
        push_exp(exp);
        pop_check(tag, got);
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.in_SC  = a;
        bus.in_PC  = d;
        bus.in_RFL = 1'b1;
        tick();
        bus.in_RFL = 1'b0;
    endtask

    task automatic reserve(input logic [AW-1:0] a);
        bus.in_rsv      = 1'b1;
        bus.in_rsv_addr = a;
        tick();
        bus.in_rsv = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic done_seen;
        logic [DW-1:0] byp_exp;

        clr_n           = 1'b0;
        bus.in_SR       = '0;
        bus.in_SC       = '0;
        bus.in_PC       = '0;
        bus.in_RFL      = 1'b0;
        bus.in_rsv      = 1'b0;
        bus.in_rsv_addr = '0;
        bus.in_clr_req  = 1'b0;
        tick();
        tick();
        clr_n = 1'b1;

        // Reset
        expect_sig("rst_busy", {31'd0, bus.out_busy}, 32'd0);
        expect_sig("rst_done", {31'd0, bus.out_done}, 32'd0);
        expect_sig("rst_state", {30'd0, bus.out_dbg_state}, 32'd0);
        write_reg(5, 32'hDEADBEEF);
        expect_rd("pre_rst_r5", 0, 5, 32'hDEADBEEF);
        reserve(5);
        expect_pend("pre_rst_pend_r5", 1, 5, 1'b1);
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        expect_rd("rst_r5", 0, 5, 32'd0);
        expect_pend("rst_pend0", 0, 5, 1'b0);
        expect_pend("rst_pend1", 1, 5, 1'b0);
        expect_sig("rst_busy2", {31'd0, bus.out_busy}, 32'd0);
        expect_sig("rst_done2", {31'd0, bus.out_done}, 32'd0);

        // Write / read on both ports
        write_reg(4, 32'h00000004);
        write_reg(3, 32'hFFFFFFFF);
        expect_rd("rd_p0_r4", 0, 4, 32'h00000004);
        expect_rd("rd_p1_r3", 1, 3, 32'hFFFFFFFF);
        write_reg(0, 32'h00001234);
        expect_rd("rd_r0_zero", 0, 0, 32'd0);
        expect_rd("rd_r0_zero_p1", 1, 0, 32'd0);

        // Bypass
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'hA5A5A5A5;
`else
        byp_exp = 32'd0;
`endif
        expect_rd("byp_r7_init", 0, 7, 32'd0);
        bus.in_SC  = 7;
        bus.in_PC  = 32'hA5A5A5A5;
        bus.in_RFL = 1'b1;
        expect_rd("byp_before_edge", 0, 7, byp_exp);
        tick();
        bus.in_RFL = 1'b0;
        expect_rd("byp_after_p0", 0, 7, 32'hA5A5A5A5);
        expect_rd("byp_after_p1", 1, 7, 32'hA5A5A5A5);

        // Scoreboard
        reserve(9);
        expect_pend("sb_rsv_r9", 0, 9, 1'b1);
        write_reg(9, 32'h00000099);
        expect_pend("sb_wr_r9", 0, 9, 1'b0);
        expect_rd("sb_wr_r9_data", 0, 9, 32'h00000099);
        bus.in_rsv      = 1'b1;
        bus.in_rsv_addr = 9;
        bus.in_SC       = 9;
        bus.in_PC       = 32'h00000077;
        bus.in_RFL      = 1'b1;
        tick();
        bus.in_rsv = 1'b0;
        bus.in_RFL = 1'b0;
        expect_pend("sb_rsv_wr_r9", 0, 9, 1'b1);
        expect_rd("sb_rsv_wr_r9_data", 1, 9, 32'h00000077);
        reserve(0);
        expect_pend("sb_rsv_r0", 0, 0, 1'b0);

        // Sweep
        for (int i = 1; i < NR; i++) write_reg(AW'(i), DW'(i));
        expect_rd("fill_r31", 0, 31, 32'd31);
        bus.in_clr_req = 1'b1;
        tick();
        bus.in_clr_req = 1'b0;
        n = 0;
        while (bus.out_busy && n < 100) begin
            if (n == 5) begin
                bus.in_SC  = 2;
                bus.in_PC  = 32'h00000055;
                bus.in_RFL = 1'b1;
            end
            if (n == 10) begin
                expect_rd("sweep_mid_r20", 1, 20, 32'd20);
                expect_rd("sweep_mid_r3", 1, 3, 32'd0);
            end
            if (n == 31) begin
                bus.in_rsv      = 1'b1;
                bus.in_rsv_addr = 1;
            end
            tick();
            bus.in_RFL = 1'b0;
            bus.in_rsv = 1'b0;
            n++;
        end
        expect_sig("sweep_busy_len", DW'(n), 32'd32);
        expect_sig("sweep_done_pulse", {31'd0, bus.out_done}, 32'd1);
        tick();
        expect_sig("sweep_done_end", {31'd0, bus.out_done}, 32'd0);
        expect_sig("sweep_busy_end", {31'd0, bus.out_busy}, 32'd0);
        for (int i = 0; i < NR; i++) begin
            expect_rd($sformatf("sweep_r%0d", i), 0, AW'(i), 32'd0);
            expect_pend($sformatf("sweep_pend_r%0d", i), 1, AW'(i), 1'b0);
        end

        // Reset mid-sweep
        for (int i = 1; i < NR; i++) write_reg(AW'(i), DW'(i + 100));
        bus.in_clr_req = 1'b1;
        tick();
        bus.in_clr_req = 1'b0;
        n = 0;
        while (bus.out_busy && n < 10) begin
            tick();
            n++;
        end
        expect_sig("abort_reached_c10", DW'(n), 32'd10);
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
        expect_sig("abort_busy", {31'd0, bus.out_busy}, 32'd0);
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_done) done_seen = 1'b1;
            tick();
        end
        expect_sig("abort_no_done", {31'd0, done_seen}, 32'd0);
        for (int i = 0; i < NR; i++) begin
            expect_rd($sformatf("abort_r%0d", i), 1, AW'(i), 32'd0);
        end
        bus.in_clr_req = 1'b1;
        tick();
        bus.in_clr_req = 1'b0;
        expect_sig("resweep_busy", {31'd0, bus.out_busy}, 32'd1);
        done_seen = 1'b0;
        for (int c = 0; c < 100 && !done_seen; c++) begin
            if (bus.out_done) done_seen = 1'b1;
            else tick();
        end
        expect_sig("resweep_done", {31'd0, done_seen}, 32'd1);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
